neural_coef_loader: RTL

- Write-side counterpart of the 2-input/2-output two-layer STRUCT_NEURAL datapath.
- Accepts a framed stream of 16-bit Q8.8 coefficient words over a valid/ready handshake and assembles them in a shadow bank.
- Once a frame is complete and hold is low, commits all eight words atomically to the active bank, which drives c111..c222 of the network.
- The network therefore never sees a partially updated weight set.

---
 rtl/neural_coef_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/neural_coef_loader.sv
// neural_coef_loader: collects a framed stream of Q8.8 coefficient words into a
// shadow bank and, once a full frame has arrived and hold is low, copies all
// eight words at once into the active bank that drives the STRUCT_NEURAL
// network. The network therefore never sees a partially updated weight set.
module neural_coef_loader #(
  parameter int               WIDTH      = 16,
  parameter int               NCOEF      = 8,
  parameter logic [WIDTH-1:0] RESET_COEF = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             hold,
  output logic [WIDTH-1:0] c111,
  output logic [WIDTH-1:0] c112,
  output logic [WIDTH-1:0] c121,
  output logic [WIDTH-1:0] c122,
  output logic [WIDTH-1:0] c211,
  output logic [WIDTH-1:0] c212,
  output logic [WIDTH-1:0] c221,
  output logic [WIDTH-1:0] c222,
  output logic             load_done,
  output logic             load_err,
  output logic             busy
);

  localparam int CW = $clog2(NCOEF);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCOEF - 1);

  typedef enum logic {
    LOAD,
    COMMIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shadow [NCOEF];
  logic [WIDTH-1:0] active [NCOEF];

  logic xfer;
  logic at_last;
  logic frame_ok;
  logic frame_bad;
  logic do_commit;

  assign xfer      = in_valid & in_ready;
  assign at_last   = (cnt == LAST_IDX);
  assign frame_ok  = xfer & at_last & in_last;
  // A mismatch between in_last and the final index covers both short and long frames.
  assign frame_bad = xfer & (in_last ^ at_last);
  assign do_commit = (state == COMMIT) & ~hold;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Next state: complete frame moves to COMMIT, commit waits for hold to drop.
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (frame_ok) state_nx = COMMIT;
      COMMIT:  if (!hold)    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Handshake and status outputs derived from state and word count.
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (cnt != '0) | (state == COMMIT);
  end

  // Word counter: restarts at zero after any frame end, good or bad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (xfer) begin
      if (in_last || at_last) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
    end
  end

  // Shadow bank: accumulates accepted words, cleared when a frame is rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCOEF; i++) shadow[i] <= '0;
    end else if (frame_bad) begin
      for (int unsigned i = 0; i < NCOEF; i++) shadow[i] <= '0;
    end else if (xfer) begin
      shadow[cnt] <= in_data;
    end
  end

  // Active bank: all words replaced together on the commit edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCOEF; i++) active[i] <= RESET_COEF;
    end else if (do_commit) begin
      for (int unsigned i = 0; i < NCOEF; i++) active[i] <= shadow[i];
    end
  end

  // Single-cycle event pulses; commit and frame errors cannot coincide since
  // no word transfers while in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= do_commit;
      load_err  <= frame_bad;
    end
  end

  assign c111 = active[0];
  assign c112 = active[1];
  assign c121 = active[2];
  assign c122 = active[3];
  assign c211 = active[4];
  assign c212 = active[5];
  assign c221 = active[6];
  assign c222 = active[7];

endmodule
